// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states
// and the default data memory size.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int DM_BYTES_DEFAULT = 256;

   typedef enum logic {
      IDLE,
      RMW_WR
   } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering between a 32-bit memory word and a sub-word access:
// extracts/extends loads and merges sub-word stores into the old word.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Byte k of the word lives in bits [31-8k -: 8]
   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_offset)
         2'd0:    w_byte = i_rdata[31:24];
         2'd1:    w_byte = i_rdata[23:16];
         2'd2:    w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
   end

   always_comb begin
      o_load = i_rdata;
      case (i_size)
         SZ_BYTE: o_load = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: o_load = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_load = i_rdata;
      endcase
   end

   always_comb begin
      o_merged = i_rdata;
      case (i_size)
         SZ_BYTE: begin
            case (i_offset)
               2'd0:    o_merged[31:24] = i_wdata[7:0];
               2'd1:    o_merged[23:16] = i_wdata[7:0];
               2'd2:    o_merged[15:8]  = i_wdata[7:0];
               default: o_merged[7:0]   = i_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (i_offset[1]) o_merged[15:0]  = i_wdata[15:0];
            else             o_merged[31:16] = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: word-wide data_mem accesses, sub-word load extension,
// read-modify-write sub-word stores, and alignment/range fault reporting.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DM_BYTES = DM_BYTES_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [1:0]        i_size,
   input  logic              i_load_unsigned,
   input  logic [DATA_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_store_data,
   input  logic [DATA_W-1:0] i_dm_rdata,
   output logic [DATA_W-1:0] o_dm_address,
   output logic [DATA_W-1:0] o_dm_writeData,
   output logic              o_dm_memread,
   output logic              o_dm_memwrite,
   output logic              o_stall,
   output logic [DATA_W-1:0] o_load_data,
   output logic              o_load_valid,
   output logic              o_misalign_exc,
   output logic              o_range_exc,
   output logic [DATA_W-1:0] o_exc_addr
);

   localparam logic [DATA_W-1:0] LAST_WORD = DATA_W'(DM_BYTES - 4);

   state_t            r_state;
   state_t            w_nextState;
   logic [DATA_W-1:0] r_rmwAddr;
   logic [DATA_W-1:0] r_mergeQ;
   logic [DATA_W-1:0] r_loadData;
   logic [DATA_W-1:0] r_excAddr;
   logic              r_loadValid;
   logic              r_misalign;
   logic              r_range;

   logic [DATA_W-1:0] w_wordAddr;
   logic [DATA_W-1:0] w_loadExt;
   logic [DATA_W-1:0] w_merged;
   logic              w_isStore;
   logic              w_isLoad;
   logic              w_active;
   logic              w_badAlign;
   logic              w_misalign;
   logic              w_range;
   logic              w_legal;
   logic              w_subStore;

   // A store wins when both mem_read and mem_write are raised
   assign w_wordAddr = {i_addr[DATA_W-1:2], 2'b00};
   assign w_isStore  = i_req_valid & i_mem_write;
   assign w_isLoad   = i_req_valid & i_mem_read & ~i_mem_write;
   assign w_active   = (r_state == IDLE) & (w_isStore | w_isLoad);

   always_comb begin
      w_badAlign = 1'b1;
      case (i_size)
         SZ_BYTE: w_badAlign = 1'b0;
         SZ_HALF: w_badAlign = i_addr[0];
         SZ_WORD: w_badAlign = |i_addr[1:0];
         default: w_badAlign = 1'b1;
      endcase
   end

   assign w_misalign = w_active & w_badAlign;
   assign w_range    = w_active & ~w_badAlign & (w_wordAddr > LAST_WORD);
   assign w_legal    = w_active & ~w_badAlign & ~(w_wordAddr > LAST_WORD);
   assign w_subStore = w_legal & w_isStore & (i_size != SZ_WORD);

   mem_lane_align u_lane (
      .i_rdata    (i_dm_rdata),
      .i_wdata    (i_store_data),
      .i_offset   (i_addr[1:0]),
      .i_size     (i_size),
      .i_unsigned (i_load_unsigned),
      .o_load     (w_loadExt),
      .o_merged   (w_merged)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState    = r_state;
      o_dm_address   = w_wordAddr;
      o_dm_writeData = i_store_data;
      o_dm_memread   = 1'b0;
      o_dm_memwrite  = 1'b0;
      o_stall        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_subStore) begin
               o_dm_memread = 1'b1;
               o_stall      = 1'b1;
               w_nextState  = RMW_WR;
            end else if (w_legal && w_isStore) begin
               o_dm_memwrite = 1'b1;
            end else if (w_legal) begin
               o_dm_memread = 1'b1;
            end
         end
         RMW_WR: begin
            o_dm_address   = r_rmwAddr;
            o_dm_writeData = r_mergeQ;
            o_dm_memwrite  = 1'b1;
            w_nextState    = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rmwAddr <= '0;
         r_mergeQ  <= '0;
      end else if (w_subStore) begin
         r_rmwAddr <= w_wordAddr;
         r_mergeQ  <= w_merged;
      end
   end

   // Result and fault pulses last exactly one cycle per accepted request
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_loadData  <= '0;
         r_excAddr   <= '0;
         r_loadValid <= 1'b0;
         r_misalign  <= 1'b0;
         r_range     <= 1'b0;
      end else begin
         r_loadValid <= w_legal & w_isLoad;
         r_misalign  <= w_misalign;
         r_range     <= w_range;
         if (w_legal && w_isLoad) r_loadData <= w_loadExt;
         if (w_misalign || w_range) r_excAddr <= i_addr;
      end
   end

   assign o_load_data    = r_loadData;
   assign o_load_valid   = r_loadValid;
   assign o_misalign_exc = r_misalign;
   assign o_range_exc    = r_range;
   assign o_exc_addr     = r_excAddr;

endmodule
